// File: rtl/regpair_pkg.sv
// Shared constants for the register-pair sequencer: op codes, pair codes,
// register indices and the sequencer state encoding.
package regpair_pkg;

  localparam logic [1:0] OP_INX  = 2'b00;
  localparam logic [1:0] OP_DCX  = 2'b01;
  localparam logic [1:0] OP_LXI  = 2'b10;
  localparam logic [1:0] OP_XCHG = 2'b11;

  localparam logic [1:0] PAIR_BC = 2'b00;
  localparam logic [1:0] PAIR_DE = 2'b01;
  localparam logic [1:0] PAIR_HL = 2'b10;
  localparam logic [1:0] PAIR_SP = 2'b11;

  localparam logic [2:0] REG_B   = 3'd0;
  localparam logic [2:0] REG_C   = 3'd1;
  localparam logic [2:0] REG_D   = 3'd2;
  localparam logic [2:0] REG_E   = 3'd3;
  localparam logic [2:0] REG_H   = 3'd4;
  localparam logic [2:0] REG_L   = 3'd5;
  localparam logic [2:0] REG_SPH = 3'd6;
  localparam logic [2:0] REG_SPL = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_RDA, S_CPA, S_RDB, S_CPB, S_WR0, S_WR1, S_WR2, S_WR3, S_DONE
  } state_t;

endpackage

// File: rtl/regpair_decode.sv
// Maps a 2-bit pair code to the register indices of its high and low byte.
module regpair_decode
  import regpair_pkg::*;
#(
  parameter int REGBIT = 3
) (
  input  logic [1:0]        pair,
  output logic [REGBIT-1:0] hi_idx,
  output logic [REGBIT-1:0] lo_idx
);

  always_comb begin
    hi_idx = REGBIT'(REG_B);
    lo_idx = REGBIT'(REG_C);
    case (pair)
      PAIR_BC: begin hi_idx = REGBIT'(REG_B);   lo_idx = REGBIT'(REG_C);   end
      PAIR_DE: begin hi_idx = REGBIT'(REG_D);   lo_idx = REGBIT'(REG_E);   end
      PAIR_HL: begin hi_idx = REGBIT'(REG_H);   lo_idx = REGBIT'(REG_L);   end
      default: begin hi_idx = REGBIT'(REG_SPH); lo_idx = REGBIT'(REG_SPL); end
    endcase
  end

endmodule

// File: rtl/regpair_sequencer.sv
// Multi-cycle INX/DCX/LXI/XCHG sequencer driving the 8-bit register file ports.
// XCHG support is built only when REGPAIR_XCHG_EN is defined.
module regpair_sequencer
  import regpair_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int REGBIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [1:0]            op,
  input  logic [1:0]            pair,
  input  logic [2*DATASIZE-1:0] imm,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATASIZE-1:0] result,
  output logic                  rf_wrenb,
  output logic [REGBIT-1:0]     rf_waddr,
  output logic [DATASIZE-1:0]   rf_wdata,
  output logic                  rf_r1enb,
  output logic [REGBIT-1:0]     rf_r1add,
  output logic                  rf_r2enb,
  output logic [REGBIT-1:0]     rf_r2add,
  input  logic [DATASIZE-1:0]   rf_r1dat,
  input  logic [DATASIZE-1:0]   rf_r2dat,
  output state_t                dbg_state
);

  localparam int PW = 2 * DATASIZE;

  state_t                state, state_next;
  logic [1:0]            op_q, pair_q;
  logic [PW-1:0]         imm_q, newval;
  logic [DATASIZE-1:0]   a_hi, a_lo;
`ifdef REGPAIR_XCHG_EN
  logic [DATASIZE-1:0]   b_hi, b_lo;
`endif
  logic [REGBIT-1:0]     hi_idx, lo_idx;
  logic [REGBIT-1:0]     waddr_q, r1add_q, r2add_q;
  logic [DATASIZE-1:0]   wdata_q;

  regpair_decode #(.REGBIT(REGBIT)) u_decode (
    .pair   (pair_q),
    .hi_idx (hi_idx),
    .lo_idx (lo_idx)
  );

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  // For XCHG the value reported is the old DE, which becomes the new HL.
  always_comb begin
    newval = {a_hi, a_lo};
    case (op_q)
      OP_INX:  newval = {a_hi, a_lo} + PW'(1);
      OP_DCX:  newval = {a_hi, a_lo} - PW'(1);
      OP_LXI:  newval = imm_q;
      default: newval = {a_hi, a_lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Port addresses and write data keep their last value outside their states.
  always_comb begin
    state_next = state;
    rf_wrenb   = 1'b0;
    rf_r1enb   = 1'b0;
    rf_r2enb   = 1'b0;
    rf_waddr   = waddr_q;
    rf_wdata   = wdata_q;
    rf_r1add   = r1add_q;
    rf_r2add   = r2add_q;
    case (state)
      S_IDLE: begin
        if (go) begin
          case (op)
            OP_LXI:  state_next = S_WR0;
`ifdef REGPAIR_XCHG_EN
            OP_XCHG: state_next = S_RDA;
`else
            OP_XCHG: state_next = S_DONE;
`endif
            default: state_next = S_RDA;
          endcase
        end
      end
      S_RDA: begin
        rf_r1enb   = 1'b1;
        rf_r2enb   = 1'b1;
        rf_r1add   = hi_idx;
        rf_r2add   = lo_idx;
`ifdef REGPAIR_XCHG_EN
        if (op_q == OP_XCHG) begin
          rf_r1add = REGBIT'(REG_D);
          rf_r2add = REGBIT'(REG_E);
        end
`endif
        state_next = S_CPA;
      end
      S_CPA: begin
        state_next = S_WR0;
`ifdef REGPAIR_XCHG_EN
        if (op_q == OP_XCHG) state_next = S_RDB;
`endif
      end
`ifdef REGPAIR_XCHG_EN
      S_RDB: begin
        rf_r1enb   = 1'b1;
        rf_r2enb   = 1'b1;
        rf_r1add   = REGBIT'(REG_H);
        rf_r2add   = REGBIT'(REG_L);
        state_next = S_CPB;
      end
      S_CPB: state_next = S_WR0;
`endif
      S_WR0: begin
        rf_wrenb   = 1'b1;
        rf_waddr   = lo_idx;
        rf_wdata   = newval[DATASIZE-1:0];
`ifdef REGPAIR_XCHG_EN
        if (op_q == OP_XCHG) begin
          rf_waddr = REGBIT'(REG_D);
          rf_wdata = b_hi;
        end
`endif
        state_next = S_WR1;
      end
      S_WR1: begin
        rf_wrenb   = 1'b1;
        rf_waddr   = hi_idx;
        rf_wdata   = newval[PW-1:DATASIZE];
        state_next = S_DONE;
`ifdef REGPAIR_XCHG_EN
        if (op_q == OP_XCHG) begin
          rf_waddr   = REGBIT'(REG_E);
          rf_wdata   = b_lo;
          state_next = S_WR2;
        end
`endif
      end
`ifdef REGPAIR_XCHG_EN
      S_WR2: begin
        rf_wrenb   = 1'b1;
        rf_waddr   = REGBIT'(REG_H);
        rf_wdata   = a_hi;
        state_next = S_WR3;
      end
      S_WR3: begin
        rf_wrenb   = 1'b1;
        rf_waddr   = REGBIT'(REG_L);
        rf_wdata   = a_lo;
        state_next = S_DONE;
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      pair_q  <= '0;
      imm_q   <= '0;
      a_hi    <= '0;
      a_lo    <= '0;
`ifdef REGPAIR_XCHG_EN
      b_hi    <= '0;
      b_lo    <= '0;
`endif
      waddr_q <= '0;
      wdata_q <= '0;
      r1add_q <= '0;
      r2add_q <= '0;
      result  <= '0;
    end else begin
      waddr_q <= rf_waddr;
      wdata_q <= rf_wdata;
      r1add_q <= rf_r1add;
      r2add_q <= rf_r2add;
      if (state == S_IDLE && go) begin
        op_q   <= op;
        pair_q <= pair;
        imm_q  <= imm;
      end
      if (state == S_CPA) begin
        a_hi <= rf_r1dat;
        a_lo <= rf_r2dat;
      end
`ifdef REGPAIR_XCHG_EN
      if (state == S_CPB) begin
        b_hi <= rf_r1dat;
        b_lo <= rf_r2dat;
      end
`endif
      // Only a completed write sequence updates result; IDLE->DONE leaves it.
      if (state_next == S_DONE && state != S_IDLE) result <= newval;
    end
  end

endmodule

// File: tb/tb_regpair_sequencer.sv
// Bench for regpair_sequencer: register-file model, directed and random ops
// checked against a pair-level arithmetic model. Honours REGPAIR_XCHG_EN.
module tb_regpair_sequencer;
  import regpair_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [1:0]  pair = 2'b00;
  logic [15:0] imm = 16'h0;
  logic        busy, done;
  logic [15:0] result;
  logic        rf_wrenb, rf_r1enb, rf_r2enb;
  logic [2:0]  rf_waddr, rf_r1add, rf_r2add;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_r1dat = 8'h0;
  logic [7:0]  rf_r2dat = 8'h0;
  state_t      dbg_state;

  logic [7:0]  rf_mem [8];
  logic [7:0]  model_rf [8];
  logic [15:0] model_result;
  logic [15:0] exp_q [$];
  int errors = 0, checks = 0;
  int done_cnt = 0, rd_cnt = 0;

  regpair_sequencer #(.DATASIZE(8), .REGBIT(3)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .pair(pair), .imm(imm),
    .busy(busy), .done(done), .result(result),
    .rf_wrenb(rf_wrenb), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_r1enb(rf_r1enb), .rf_r1add(rf_r1add),
    .rf_r2enb(rf_r2enb), .rf_r2add(rf_r2add),
    .rf_r1dat(rf_r1dat), .rf_r2dat(rf_r2dat),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // register file: synchronous write, one-cycle read latency
  always @(posedge clk) begin
    if (rf_wrenb) rf_mem[rf_waddr] <= rf_wdata;
    if (rf_r1enb) rf_r1dat <= rf_mem[rf_r1add];
    if (rf_r2enb) rf_r2dat <= rf_mem[rf_r2add];
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rf_r1enb || rf_r2enb) rd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_rf();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = rf_mem[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = model_rf[i];
    return v;
  endfunction

  function automatic int exp_latency(input logic [1:0] o);
    case (o)
      OP_LXI:  return 3;
`ifdef REGPAIR_XCHG_EN
      OP_XCHG: return 9;
`else
      OP_XCHG: return 1;
`endif
      default: return 5;
    endcase
  endfunction

  function automatic logic [15:0] get_pair(input int p);
    return {model_rf[2*p], model_rf[2*p+1]};
  endfunction

  function automatic void set_pair(input int p, input logic [15:0] v);
    model_rf[2*p]   = v[15:8];
    model_rf[2*p+1] = v[7:0];
  endfunction

  // Pair-level behaviour: returns the value result should show after the op.
  function automatic logic [15:0] model_apply(input logic [1:0] o, input logic [1:0] p,
                                              input logic [15:0] im);
    logic [15:0] de, hl;
    case (o)
      OP_INX: begin set_pair(int'(p), get_pair(int'(p)) + 16'd1); model_result = get_pair(int'(p)); end
      OP_DCX: begin set_pair(int'(p), get_pair(int'(p)) - 16'd1); model_result = get_pair(int'(p)); end
      OP_LXI: begin set_pair(int'(p), im); model_result = im; end
      default: begin
`ifdef REGPAIR_XCHG_EN
        de = get_pair(1);
        hl = get_pair(2);
        set_pair(1, hl);
        set_pair(2, de);
        model_result = de;
`else
        de = 16'h0;
        hl = 16'h0;
`endif
      end
    endcase
    return model_result;
  endfunction

  task automatic preload(input logic [1:0] p, input logic [15:0] v);
    rf_mem[{p, 1'b0}] = v[15:8];
    rf_mem[{p, 1'b1}] = v[7:0];
    set_pair(int'(p), v);
  endtask

  // Drive one request and follow it to completion.
  task automatic run_op(input logic [1:0] o, input logic [1:0] p, input logic [15:0] im,
                        input string tag);
    int lat, cyc, rd0;
    bit found;
    lat = exp_latency(o);
    exp_q.push_back(model_apply(o, p, im));
    rd0 = rd_cnt;
    @(posedge clk); #1;
    go = 1'b1; op = o; pair = p; imm = im;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 1;
    found = 1'b0;
    @(negedge clk);
    check({tag, " busy_c1"}, 64'(busy), 64'(1));
    while (!found && cyc <= 20) begin
      if (done) found = 1'b1;
      else begin
        @(posedge clk); #1;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, " latency"}, 64'(found ? cyc : 99), 64'(lat));
    check({tag, " result"}, 64'(result), 64'(exp_q.pop_front()));
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " idle_after"}, 64'({busy, done}), 64'(0));
    check({tag, " regs"}, pack_rf(), pack_model());
    if (o == OP_LXI) check({tag, " no_reads"}, 64'(rd_cnt - rd0), 64'(0));
  endtask

  initial begin
    int dc0;
    logic [1:0] ro, rp;
    logic [15:0] rv;
    for (int i = 0; i < 8; i++) begin
      rf_mem[i]   = 8'h0;
      model_rf[i] = 8'h0;
    end
    model_result = 16'h0;

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({busy, done, result, rf_wrenb, rf_waddr, rf_wdata,
               rf_r1enb, rf_r1add, rf_r2enb, rf_r2add}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // directed
    preload(PAIR_BC, 16'h12FF);
    run_op(OP_INX, PAIR_BC, 16'h0, "inx_bc");
    check("inx_bc const", 64'({rf_mem[0], rf_mem[1], result}), 64'(32'h1300_1300));

    preload(PAIR_SP, 16'h0000);
    run_op(OP_DCX, PAIR_SP, 16'h0, "dcx_sp");
    check("dcx_sp const", 64'({rf_mem[6], rf_mem[7], result}), 64'(32'hFFFF_FFFF));

    preload(PAIR_DE, 16'hFFFF);
    run_op(OP_INX, PAIR_DE, 16'h0, "inx_wrap");
    check("inx_wrap const", 64'({rf_mem[2], rf_mem[3]}), 64'(0));

    run_op(OP_LXI, PAIR_HL, 16'hBEEF, "lxi_hl");
    check("lxi_hl const", 64'({rf_mem[4], rf_mem[5]}), 64'(16'hBEEF));

    preload(PAIR_DE, 16'h1234);
    preload(PAIR_HL, 16'h5678);
    run_op(OP_XCHG, PAIR_BC, 16'h0, "xchg");
`ifdef REGPAIR_XCHG_EN
    check("xchg const", 64'({rf_mem[2], rf_mem[3], rf_mem[4], rf_mem[5]}), 64'(32'h5678_1234));
`else
    check("xchg const", 64'({rf_mem[2], rf_mem[3], rf_mem[4], rf_mem[5]}), 64'(32'h1234_5678));
`endif

    // go during a running INX is ignored
    preload(PAIR_BC, 16'h00FF);
    void'(model_apply(OP_INX, PAIR_BC, 16'h0));
    dc0 = done_cnt;
    @(posedge clk); #1;
    go = 1'b1; op = OP_INX; pair = PAIR_BC;
    @(posedge clk); #1; go = 1'b0;
    @(posedge clk); #1; go = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; go = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("go_ignored done_count", 64'(done_cnt - dc0), 64'(1));
    check("go_ignored regs", pack_rf(), pack_model());
    check("go_ignored result", 64'(result), 64'(16'h0100));

    // reset in the first write cycle of INX BC from 12FF
    preload(PAIR_BC, 16'h12FF);
    model_rf[1] = 8'h00;
    dc0 = done_cnt;
    @(posedge clk); #1;
    go = 1'b1; op = OP_INX; pair = PAIR_BC;
    @(posedge clk); #1; go = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_mid idle_c4", 64'({busy, done, dbg_state == S_IDLE}), 64'(3'b001));
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid no_done", 64'(done_cnt - dc0), 64'(0));
    check("rst_mid regs", pack_rf(), pack_model());
    model_result = 16'h0;

    // rst and go together: request dropped
    dc0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1; go = 1'b1; op = OP_LXI; pair = PAIR_HL; imm = 16'h1111;
    @(posedge clk); #1;
    rst = 1'b0; go = 1'b0;
    @(negedge clk);
    check("rst_go busy", 64'(busy), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    check("rst_go dropped", 64'({done_cnt - dc0, 16'(result)}), 64'(0));
    check("rst_go regs", pack_rf(), pack_model());

    // random
    for (int n = 0; n < 24; n++) begin
      ro = 2'($urandom_range(0, 3));
      rp = 2'($urandom_range(0, 3));
      rv = 16'($urandom);
      case ($urandom_range(0, 3))
        0: preload(rp, 16'hFFFF);
        1: preload(rp, 16'h0000);
        2: preload(rp, rv);
        default: ;
      endcase
      run_op(ro, rp, 16'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
